ppu_fb_arbiter: RTL and testbench

- Shares one single-port frame-buffer RAM between two requesters: the PPU pixel writer and the VGA scan-out reader.
- PPU writes 6-bit palette indices through a small write FIFO. The VGA side consumes the beam counters (hc, vc) and returns palette_disp_idx, which is timed to the current pixel and feeds the palette-to-RGB display logic.
- VGA reads have absolute priority. Queued writes drain only in slots that are not needed for a read.

---
 rtl/ppu_fb_arbiter.sv | 155 +++++++++++++++
 tb/tb_ppu_fb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ppu_fb_arbiter.sv
// Frame-buffer RAM arbiter: VGA scan-out reads take every slot they need, and
// queued PPU writes drain in the remaining slots. Define FB_SCALE2X_EN for 2x pixel doubling.
module ppu_fb_arbiter #(
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525,
  parameter int ACT_W      = 256,
  parameter int ACT_H      = 240,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [9:0]                    hc,
  input  logic [9:0]                    vc,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [7:0]                    wr_x,
  input  logic [7:0]                    wr_y,
  input  logic [5:0]                    wr_data,
  output logic [15:0]                   ram_addr,
  output logic                          ram_we,
  output logic [5:0]                    ram_wdata,
  input  logic [5:0]                    ram_rdata,
  output logic [5:0]                    palette_disp_idx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef FB_SCALE2X_EN
  localparam int DISP_W = 2 * ACT_W;
  localparam int DISP_H = 2 * ACT_H;
`else
  localparam int DISP_W = ACT_W;
  localparam int DISP_H = ACT_H;
`endif
  localparam logic [10:0]      H_TOT_L  = 11'(H_TOTAL);
  localparam logic [10:0]      V_TOT_L  = 11'(V_TOTAL);
  localparam logic [10:0]      DISP_W_L = 11'(DISP_W);
  localparam logic [10:0]      DISP_H_L = 11'(DISP_H);
  localparam logic [8:0]       ACT_H_L  = 9'(ACT_H);
  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [5:0]       BLACK    = 6'h0F;

  logic [10:0] fh_sum, fh, fv;
  logic        in_range, disp_area, read_slot, hold_slot;
  logic [15:0] rd_addr;

  logic [21:0]      fifo_mem_q [FIFO_DEPTH];
  logic [21:0]      head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push, pop;

  logic [15:0] ram_addr_q, ram_addr_d;
  logic        ram_we_q, ram_we_d;
  logic [5:0]  ram_wdata_q, ram_wdata_d;
  logic [5:0]  pix_q, pix_d;
  logic        rd_pend_q, rd_pend_d;
  logic        hold_q, hold_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Fetch runs two pixels ahead of the beam, wrapping into the next line/frame.
  always_comb begin
    fh_sum = {1'b0, hc} + 11'd2;
    fh     = fh_sum;
    fv     = {1'b0, vc};
    if (fh_sum >= H_TOT_L) begin
      fh = fh_sum - H_TOT_L;
      fv = {1'b0, vc} + 11'd1;
    end
    if (fv == V_TOT_L) fv = '0;
    in_range  = ({1'b0, hc} < H_TOT_L) && ({1'b0, vc} < V_TOT_L);
    disp_area = in_range && (fh < DISP_W_L) && (fv < DISP_H_L);
`ifdef FB_SCALE2X_EN
    read_slot = disp_area && !fh[0];
    hold_slot = disp_area && fh[0];
    rd_addr   = {fv[8:1], fh[8:1]};
`else
    read_slot = disp_area;
    hold_slot = 1'b0;
    rd_addr   = {fv[7:0], fh[7:0]};
`endif
  end

  assign head     = fifo_mem_q[rd_ptr_q];
  assign wr_ready = (level_q != DEPTH_L);
  assign push     = wr_valid && wr_ready;
  assign pop      = !read_slot && (level_q != '0);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    drop_cnt_d  = drop_cnt_q;
    rd_pend_d   = read_slot;
    hold_d      = hold_slot;
    if (read_slot) begin
      ram_addr_d = rd_addr;
    end else if (pop) begin
      // Entry layout: {y[7:0], x[7:0], data[5:0]}
      if ({1'b0, head[21:14]} < ACT_H_L) begin
        ram_we_d    = 1'b1;
        ram_addr_d  = head[21:6];
        ram_wdata_d = head[5:0];
      end else if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end
    end
    if (rd_pend_q)   pix_d = ram_rdata;
    else if (hold_q) pix_d = pix_q;
    else             pix_d = BLACK;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {wr_y, wr_x, wr_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      pix_q       <= BLACK;
      rd_pend_q   <= 1'b0;
      hold_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      pix_q       <= pix_d;
      rd_pend_q   <= rd_pend_d;
      hold_q      <= hold_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign ram_addr         = ram_addr_q;
  assign ram_we           = ram_we_q;
  assign ram_wdata        = ram_wdata_q;
  assign palette_disp_idx = pix_q;
  assign fifo_level       = level_q;
  assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_ppu_fb_arbiter.sv
// Directed bench for ppu_fb_arbiter with a behavioural single-port RAM
// (combinational read of the registered address, write on the clock edge).
module tb_ppu_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  hc, vc;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x, wr_y;
  logic [5:0]  wr_data;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [5:0]  ram_wdata, ram_rdata, palette_disp_idx;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;

  logic [5:0]  mem [65536];
  logic        pre_en;
  logic [15:0] pre_addr;
  logic [5:0]  pre_data;

  int checks = 0;
  int errors = 0;
  int early;

  always #5 clk = ~clk;

  ppu_fb_arbiter dut (
    .clk(clk), .reset(reset), .hc(hc), .vc(vc),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .palette_disp_idx(palette_disp_idx), .fifo_level(fifo_level), .drop_cnt(drop_cnt)
  );

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit adv);
    @(posedge clk); #1;
    if (adv) begin
      if (hc == 10'd799) begin
        hc = 10'd0;
        vc = (vc == 10'd524) ? 10'd0 : vc + 10'd1;
      end else begin
        hc = hc + 10'd1;
      end
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [5:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic drive_wr(input bit v, input logic [7:0] x, input logic [7:0] y, input logic [5:0] d);
    wr_valid = v; wr_x = x; wr_y = y; wr_data = d;
  endtask

  initial begin
    reset = 1'b1; hc = 10'd0; vc = 10'd300;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    drive_wr(1'b0, 8'd0, 8'd0, 6'd0);
    #2;
`ifdef FB_SCALE2X_EN
    preload(16'h0000, 6'h30);
    tick(0);
    hc = 10'd797; vc = 10'd524; reset = 1'b0;
    tick(1); tick(1);
    chk("s2x_addr0", ram_addr, 32'h0000);
    tick(1); chk("s2x_v0_h0", palette_disp_idx, 32'h30);
    tick(1); chk("s2x_v0_h1", palette_disp_idx, 32'h30);
    hc = 10'd798; vc = 10'd0;
    tick(1);
    chk("s2x_addr_row1", ram_addr, 32'h0000);
    tick(1); chk("s2x_v1_h0", palette_disp_idx, 32'h30);
    tick(1); chk("s2x_v1_h1", palette_disp_idx, 32'h30);
`else
    preload(16'h0000, 6'h21);
    preload(16'h0001, 6'h16);
    chk("rst_pix", palette_disp_idx, 32'h0F);
    chk("rst_level", fifo_level, 32'd0);
    chk("rst_we", ram_we, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_drop", drop_cnt, 32'd0);
    chk("rst_ready", wr_ready, 32'd1);

    // Frame wrap: the last two cycles of the last line fetch row 0.
    hc = 10'd797; vc = 10'd524; reset = 1'b0;
    tick(1); chk("wrap_black", palette_disp_idx, 32'h0F);
    tick(1); chk("wrap_addr0", ram_addr, 32'h0000);
    tick(1); chk("wrap_pix_h0", palette_disp_idx, 32'h21);
    chk("wrap_addr1", ram_addr, 32'h0001);
    tick(1); chk("wrap_pix_h1", palette_disp_idx, 32'h16);

    // Single write in the free part of a line.
    hc = 10'd300; vc = 10'd0;
    drive_wr(1'b1, 8'd5, 8'd3, 6'h2A);
    tick(1); drive_wr(1'b0, 8'd0, 8'd0, 6'd0);
    chk("wr1_level", fifo_level, 32'd1);
    chk("wr1_we_lat", ram_we, 32'd0);
    tick(1);
    chk("wr1_we", ram_we, 32'd1);
    chk("wr1_addr", ram_addr, 32'h0305);
    chk("wr1_data", ram_wdata, 32'h2A);
    chk("wr1_level0", fifo_level, 32'd0);
    tick(1);
    chk("wr1_we_pulse", ram_we, 32'd0);
    chk("wr1_addr_hold", ram_addr, 32'h0305);

    // Fill the FIFO during read slots; drain starts at the first free slot.
    hc = 10'd0; vc = 10'd10;
    for (int i = 0; i < 16; i++) begin
      drive_wr(1'b1, 8'(i), 8'd20, 6'(i + 1));
      tick(1);
    end
    chk("full_level", fifo_level, 32'd16);
    chk("full_ready", wr_ready, 32'd0);
    chk("full_we", ram_we, 32'd0);
    drive_wr(1'b1, 8'hEE, 8'd20, 6'h3F);
    tick(1); drive_wr(1'b0, 8'd0, 8'd0, 6'd0);
    chk("full_no_push", fifo_level, 32'd16);
    early = 0;
    for (int n = 0; n < 300 && hc != 10'd254; n++) begin
      tick(1);
      if (ram_we) early++;
    end
    chk("full_reach_254", hc, 32'd254);
    chk("full_early_we", early, 32'd0);
    chk("full_ready_pop", wr_ready, 32'd0);
    for (int k = 0; k < 16; k++) begin
      tick(1);
      chk("drain_we", ram_we, 32'd1);
      chk("drain_addr", ram_addr, {16'd0, 8'd20, 8'(k)});
      chk("drain_data", ram_wdata, 32'(k + 1));
    end
    chk("drain_level", fifo_level, 32'd0);
    tick(1); chk("drain_end_we", ram_we, 32'd0);

    // Out-of-range row is dropped.
    hc = 10'd300; vc = 10'd0;
    drive_wr(1'b1, 8'd1, 8'd240, 6'd5);
    tick(1); drive_wr(1'b0, 8'd0, 8'd0, 6'd0);
    chk("drop_level1", fifo_level, 32'd1);
    tick(1);
    chk("drop_we", ram_we, 32'd0);
    chk("drop_cnt", drop_cnt, 32'd1);
    chk("drop_level0", fifo_level, 32'd0);

    // hc beyond H_TOTAL is a free slot even though hc+2 would alias into the display.
    hc = 10'd1000; vc = 10'd0;
    drive_wr(1'b1, 8'd7, 8'd7, 6'd3);
    tick(0); drive_wr(1'b0, 8'd0, 8'd0, 6'd0);
    tick(0);
    chk("oor_we", ram_we, 32'd1);
    chk("oor_addr", ram_addr, 32'h0707);

    // Reset with entries queued during read slots.
    hc = 10'd100; vc = 10'd0;
    for (int i = 0; i < 5; i++) begin
      drive_wr(1'b1, 8'(i), 8'd50, 6'(i));
      tick(1);
    end
    drive_wr(1'b0, 8'd0, 8'd0, 6'd0);
    chk("mid_level5", fifo_level, 32'd5);
    reset = 1'b1; #1;
    chk("mid_rst_level", fifo_level, 32'd0);
    chk("mid_rst_we", ram_we, 32'd0);
    chk("mid_rst_pix", palette_disp_idx, 32'h0F);
    chk("mid_rst_drop", drop_cnt, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; hc = 10'd300;
    early = 0;
    for (int n = 0; n < 20; n++) begin
      tick(1);
      if (ram_we) early++;
    end
    chk("mid_no_writes", early, 32'd0);
    chk("mid_level_post", fifo_level, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
